// File: rtl/kbd_scan_ctrl_if.sv
// Receiver-side and display-side signals of the scan-code sequencer.
// master is the controller; slave is the receiver/display environment.
interface kbd_scan_ctrl_if #(
    parameter int COUNT_W = 8
);
    logic [7:0]         ps2_data;
    logic               ps2_ready;
    logic               ps2_overflow;
    logic               nextdata_n;
    logic [7:0]         key_code;
    logic               pressing;
    logic               key_ext;
    logic               key_valid;
    logic [COUNT_W-1:0] press_count;
    logic               ovf_flag;

    modport master (
        input  ps2_data, ps2_ready, ps2_overflow,
        output nextdata_n, key_code, pressing, key_ext, key_valid, press_count, ovf_flag
    );

    modport slave (
        output ps2_data, ps2_ready, ps2_overflow,
        input  nextdata_n, key_code, pressing, key_ext, key_valid, press_count, ovf_flag
    );
endinterface

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-code sequencer: pops receiver bytes, decodes make/F0/E0 (E0 tracking under KBD_EXT_CODE_EN).
// Latency: byte is decoded 3 cycles after ps2_ready is seen; one pop per 3 cycles, waits while receiver is empty.
module kbd_scan_ctrl #(
    parameter int         COUNT_W    = 8,
    parameter logic [7:0] BREAK_CODE = 8'hF0,
    parameter logic [7:0] EXT_CODE   = 8'hE0
) (
    input  logic             clk,
    input  logic             clrn,
    kbd_scan_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    state_t             state, state_nxt;
    logic               nextdata_n_r, nextdata_n_nxt;
    logic [7:0]         byte_reg, byte_nxt;
    logic [7:0]         key_code_r, key_code_nxt;
    logic               pressing_r, pressing_nxt;
    logic               key_valid_r, key_valid_nxt;
    logic [COUNT_W-1:0] count_r, count_nxt;
    logic               ovf_r, ovf_nxt;
    logic               break_pend, break_nxt;
`ifdef KBD_EXT_CODE_EN
    logic               ext_pend, ext_nxt;
    logic               key_ext_r, key_ext_nxt;
`endif

    logic held_match;
    assign held_match = pressing_r && (byte_reg == key_code_r);

    always_comb begin
        state_nxt      = state;
        nextdata_n_nxt = 1'b1;
        byte_nxt       = byte_reg;
        key_code_nxt   = key_code_r;
        pressing_nxt   = pressing_r;
        key_valid_nxt  = 1'b0;
        count_nxt      = count_r;
        break_nxt      = break_pend;
        ovf_nxt        = ovf_r | bus.ps2_overflow;
`ifdef KBD_EXT_CODE_EN
        ext_nxt        = ext_pend;
        key_ext_nxt    = key_ext_r;
`endif
        case (state)
            IDLE: begin
                if (bus.ps2_ready) begin
                    byte_nxt       = bus.ps2_data;
                    nextdata_n_nxt = 1'b0;
                    state_nxt      = POP;
                end
            end
            POP: state_nxt = DECODE;
            DECODE: begin
                state_nxt = IDLE;
                if (byte_reg == BREAK_CODE) begin
                    break_nxt = 1'b1;
                end else if (byte_reg == EXT_CODE) begin
`ifdef KBD_EXT_CODE_EN
                    ext_nxt = 1'b1;
`endif
                end else if (break_pend) begin
                    // Releases only the held key; breaks for other codes are dropped.
                    if (held_match) pressing_nxt = 1'b0;
                    break_nxt = 1'b0;
`ifdef KBD_EXT_CODE_EN
                    ext_nxt   = 1'b0;
`endif
                end else if (!held_match) begin
                    key_code_nxt  = byte_reg;
                    pressing_nxt  = 1'b1;
                    count_nxt     = count_r + 1'b1;
                    key_valid_nxt = 1'b1;
`ifdef KBD_EXT_CODE_EN
                    key_ext_nxt   = ext_pend;
                    ext_nxt       = 1'b0;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Overflow wins over any decode in the same cycle: prefix context is untrustworthy.
        if (bus.ps2_overflow) begin
            break_nxt = 1'b0;
`ifdef KBD_EXT_CODE_EN
            ext_nxt   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state        <= IDLE;
            nextdata_n_r <= 1'b1;
            byte_reg     <= 8'h00;
            key_code_r   <= 8'h00;
            pressing_r   <= 1'b0;
            key_valid_r  <= 1'b0;
            count_r      <= '0;
            ovf_r        <= 1'b0;
            break_pend   <= 1'b0;
`ifdef KBD_EXT_CODE_EN
            ext_pend     <= 1'b0;
            key_ext_r    <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            nextdata_n_r <= nextdata_n_nxt;
            byte_reg     <= byte_nxt;
            key_code_r   <= key_code_nxt;
            pressing_r   <= pressing_nxt;
            key_valid_r  <= key_valid_nxt;
            count_r      <= count_nxt;
            ovf_r        <= ovf_nxt;
            break_pend   <= break_nxt;
`ifdef KBD_EXT_CODE_EN
            ext_pend     <= ext_nxt;
            key_ext_r    <= key_ext_nxt;
`endif
        end
    end

    assign bus.nextdata_n  = nextdata_n_r;
    assign bus.key_code    = key_code_r;
    assign bus.pressing    = pressing_r;
    assign bus.key_valid   = key_valid_r;
    assign bus.press_count = count_r;
    assign bus.ovf_flag    = ovf_r;
`ifdef KBD_EXT_CODE_EN
    assign bus.key_ext     = key_ext_r;
`else
    assign bus.key_ext     = 1'b0;
`endif
endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Sequencing controller between the PS/2 receiver FIFO and the scan-code display block.
- Pops bytes from the receiver with a ready/nextdata_n handshake and decodes make, break (F0) and extended (E0) prefixes.
- Tracks the currently held key and counts distinct key presses.
- Drives key_code/pressing into the 7-segment display datapath.

Parameters:
COUNT_W, 8, width of press counter (wraps modulo 2^COUNT_W)
BREAK_CODE, 8'hF0, break prefix byte
EXT_CODE, 8'hE0, extended prefix byte

Ports:
clk  input  1  system clock, all logic on rising edge
clrn  input  1  synchronous active-low reset
ps2_data  input  8  receiver FIFO head byte, valid while ps2_ready=1
ps2_ready  input  1  receiver FIFO non-empty
ps2_overflow  input  1  receiver FIFO overflow indication
nextdata_n  output  1  registered active-low pop strobe to receiver
key_code  output  8  scan code of last made key (to display data)
pressing  output  1  1 while key_code is held (to display pressing)
key_ext  output  1  key_code came with E0 prefix (see optional feature)
key_valid  output  1  one-cycle pulse on each new counted press
press_count  output  COUNT_W  number of counted presses
ovf_flag  output  1  sticky receiver-overflow flag

Behaviour:
- Reset (clrn=0 at clk edge): state=IDLE, nextdata_n=1, key_code=0, pressing=0, key_ext=0, key_valid=0, press_count=0, ovf_flag=0, break_pend=0, ext_pend=0, byte_reg=0.
- FSM states: IDLE, POP, DECODE.
  - IDLE: if ps2_ready=1, latch ps2_data into byte_reg, set nextdata_n<=0, go to POP. Otherwise stay in IDLE.
  - POP: nextdata_n is 0 for exactly this cycle (the receiver pops on this edge). Set nextdata_n<=1, go to DECODE.
  - DECODE: apply the decode rules below, then go to IDLE. ps2_ready is not sampled in this state; the receiver pointer has settled.
- Throughput: at most one byte per 3 cycles. nextdata_n is never low for two consecutive cycles.
- Decode rules, applied to byte_reg in DECODE:
  - byte=BREAK_CODE: break_pend<=1.
  - byte=EXT_CODE: handled per optional feature.
  - otherwise, if break_pend=1 (break of a code):
    - if the code equals key_code and pressing=1, then pressing<=0.
    - a break for a non-held code is ignored.
    - in all cases break_pend<=0 and ext_pend<=0.
  - otherwise (make code):
    - if pressing=1 and the code equals key_code, treat it as a typematic repeat: no count, no key_valid, state unchanged.
    - else key_code<=byte, pressing<=1, key_ext<=ext_pend, press_count<=press_count+1 (wrapping from all-ones to 0), key_valid<=1 for one cycle, ext_pend<=0.
- key_valid is 0 in every cycle except the one following a counted make.
- Overflow:
  - ps2_overflow=1 in any cycle sets ovf_flag<=1; it stays set until reset.
  - The same cycle also clears break_pend and ext_pend.
  - The FSM continues popping normally.
- Simultaneous events: an overflow in a DECODE cycle applies after the decode, so pend flags end up cleared.
- Reset mid-operation: reset in POP or DECODE discards byte_reg. Any byte popped on that edge is lost and is not decoded. nextdata_n returns to 1.
- ps2_ready falling while the FSM is in POP is ignored; the latched byte is still decoded.

Optional Feature:
Macro KBD_EXT_CODE_EN.
- Defined:
  - EXT_CODE sets ext_pend<=1.
  - The next make code copies ext_pend into key_ext.
  - An E0 F0 xx sequence releases the held key only if xx equals key_code.
- Undefined:
  - EXT_CODE bytes are popped and discarded with no state change.
  - key_ext is tied to 0.
  - ext_pend logic is absent.

Test Plan:
- Reset, then feed 1C: one nextdata_n low pulse, 3 cycles later key_code=1C, pressing=1, press_count=1, key_valid pulses once.
- Feed 1C 1C 1C F0 1C: press_count remains 1, key_valid pulses once, pressing=0 after the final byte, key_code stays 1C.
- Press 1C, then feed F0 32 (break of a non-held key): pressing stays 1, key_code=1C. Then feed 32: key_code=32, press_count=2.
- Hold ps2_ready=1 for 6 bytes: nextdata_n has exactly 6 single-cycle low pulses spaced 3 cycles apart. Assert ps2_overflow once: ovf_flag=1 until clrn=0.
- Preload press_count via 255 distinct makes, then one more make: press_count wraps 0xFF to 0x00 and key_valid still pulses.
- With KBD_EXT_CODE_EN, feed E0 75 then E0 F0 75: key_code=75, key_ext=1, then pressing=0. Without the macro, the same stimulus gives key_ext=0 and the same pressing sequence.
